// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencer: applies frame config, arms the receiver, buffers good bytes
// in a small FIFO and recovers the receiver after errored or stalled frames.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic       rx_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] cfg_data_len,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_type,
    input  logic       cfg_stop2,
    input  logic       rx,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_err,
    output logic       rx_start,
    output logic [3:0] data_len,
    output logic       parity_en,
    output logic       parity_type,
    output logic       stop2,
    output logic       rx_rst_n,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       overflow,
    output logic [7:0] err_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RECOVER  = 2'd2
    } state_t;

    state_t        state_q;
    logic          rx_start_q;
    logic [3:0]    data_len_q;
    logic          parity_en_q;
    logic          parity_type_q;
    logic          stop2_q;
    logic          rx_rst_n_q;
    logic          busy_q;
    logic          err_seen_q;
    logic [TW-1:0] tmo_q;
    logic          rec_q;
    logic          done_prev_q;
    logic          err_prev_q;
    logic [7:0]    err_count_q;
    logic          overflow_q;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;

    logic [3:0] cfg_len_c;
    logic       done_rise_c;
    logic       err_rise_c;
    logic       armed_c;
    logic       frame_bad_c;
    logic       timeout_c;
    logic       full_c;
    logic       pop_c;
    logic       push_req_c;
    logic       push_c;
    logic       drop_c;
    logic       err_evt_c;

    // Event decode; a done rise on the timeout edge wins over the timeout
    always_comb begin
        cfg_len_c   = ((cfg_data_len >= 4'd5) && (cfg_data_len <= 4'd8)) ? cfg_data_len : 4'd8;
        done_rise_c = rx_done & ~done_prev_q;
        err_rise_c  = rx_err & ~err_prev_q;
        armed_c     = (state_q == ST_ARMED);
        frame_bad_c = err_seen_q | rx_err;
        timeout_c   = busy_q & (tmo_q == TMO_LAST) & ~done_rise_c;
        full_c      = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
        pop_c       = m_valid_q & m_ready;
        push_req_c  = armed_c & done_rise_c & ~frame_bad_c;
        push_c      = push_req_c & (~full_c | pop_c);
        drop_c      = push_req_c & full_c & ~pop_c;
        err_evt_c   = armed_c & ((done_rise_c & frame_bad_c) | timeout_c);
    end

    // Controller state machine with registered outputs
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_DISABLED;
            rx_start_q    <= 1'b0;
            data_len_q    <= 4'd8;
            parity_en_q   <= 1'b0;
            parity_type_q <= 1'b0;
            stop2_q       <= 1'b0;
            rx_rst_n_q    <= 1'b1;
            busy_q        <= 1'b0;
            err_seen_q    <= 1'b0;
            tmo_q         <= '0;
            rec_q         <= 1'b0;
            done_prev_q   <= 1'b0;
            err_prev_q    <= 1'b0;
            err_count_q   <= 8'd0;
            overflow_q    <= 1'b0;
        end else begin
            done_prev_q <= rx_done;
            err_prev_q  <= rx_err;
            if (err_evt_c && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
            if (drop_c) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_DISABLED: begin
                    data_len_q    <= cfg_len_c;
                    parity_en_q   <= cfg_parity_en;
                    parity_type_q <= cfg_parity_type;
                    stop2_q       <= cfg_stop2;
                    if (enable) begin
                        state_q    <= ST_ARMED;
                        rx_start_q <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (err_rise_c) begin
                        err_seen_q <= 1'b1;
                    end
                    if (busy_q) begin
                        tmo_q <= tmo_q + TW'(1);
                    end else if (!rx) begin
                        busy_q <= 1'b1;
                        tmo_q  <= '0;
                    end
                    if (err_evt_c) begin
                        state_q    <= ST_RECOVER;
                        rx_start_q <= 1'b0;
                        rx_rst_n_q <= 1'b0;
                        busy_q     <= 1'b0;
                        err_seen_q <= 1'b0;
                        tmo_q      <= '0;
                        rec_q      <= 1'b0;
                    end else if (done_rise_c) begin
                        busy_q <= 1'b0;
                        tmo_q  <= '0;
                    end else if (!enable && !busy_q) begin
                        state_q    <= ST_DISABLED;
                        rx_start_q <= 1'b0;
                    end
                end
                ST_RECOVER: begin
                    busy_q     <= 1'b0;
                    err_seen_q <= 1'b0;
                    tmo_q      <= '0;
                    if (rec_q) begin
                        state_q    <= enable ? ST_ARMED : ST_DISABLED;
                        rx_start_q <= enable;
                        rx_rst_n_q <= 1'b1;
                    end else begin
                        rec_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_DISABLED;
                    rx_start_q <= 1'b0;
                    rx_rst_n_q <= 1'b1;
                end
            endcase
        end
    end

    // FIFO next state; the registered head tracks a write into an otherwise empty FIFO
    always_comb begin
        wr_d      = wr_q + PW'(push_c);
        rd_d      = rd_q + PW'(pop_c);
        m_valid_d = (wr_d != rd_d);
        if (push_c && (rd_d[AW-1:0] == wr_q[AW-1:0])) begin
            m_data_d = rx_data;
        end else begin
            m_data_d = mem_q[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'd0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            if (push_c) begin
                mem_q[wr_q[AW-1:0]] <= rx_data;
            end
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign rx_start    = rx_start_q;
    assign data_len    = data_len_q;
    assign parity_en   = parity_en_q;
    assign parity_type = parity_type_q;
    assign stop2       = stop2_q;
    assign rx_rst_n    = rx_rst_n_q;
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign overflow    = overflow_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed/randomized bench for uart_rx_ctrl against a frame-level scoreboard model.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 256;

    logic       rx_clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] cfg_data_len;
    logic       cfg_parity_en;
    logic       cfg_parity_type;
    logic       cfg_stop2;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_err;
    logic       rx_start;
    logic [3:0] data_len;
    logic       parity_en;
    logic       parity_type;
    logic       stop2;
    logic       rx_rst_n;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       overflow;
    logic [7:0] err_count;

    always #5 rx_clk = ~rx_clk;

    uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .rx_clk(rx_clk), .rst(rst), .enable(enable),
        .cfg_data_len(cfg_data_len), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_type(cfg_parity_type), .cfg_stop2(cfg_stop2),
        .rx(rx), .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
        .rx_start(rx_start), .data_len(data_len), .parity_en(parity_en),
        .parity_type(parity_type), .stop2(stop2), .rx_rst_n(rx_rst_n),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .overflow(overflow), .err_count(err_count)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] q[$];
    int         exp_err  = 0;
    bit         exp_ovf  = 1'b0;
    int         rst_low  = 0;
    bit         pend_push = 1'b0;
    bit         pend_err  = 1'b0;
    logic [7:0] pend_byte = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: check the head before the edge, apply frame events to the model, check after
    task automatic step();
        bit will_pop;
        chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
        will_pop = m_ready && (q.size() != 0);
        if (will_pop) chk("m_data", 32'(m_data), 32'(q[0]));
        @(posedge rx_clk);
        if (will_pop) void'(q.pop_front());
        if (pend_push) begin
            if (q.size() < int'(DEPTH)) q.push_back(pend_byte);
            else exp_ovf = 1'b1;
        end
        if (pend_err) begin
            if (exp_err < 255) exp_err++;
            rst_low = 2;
        end
        pend_push = 1'b0;
        pend_err  = 1'b0;
        @(negedge rx_clk);
        chk("rx_rst_n", 32'(rx_rst_n), 32'(rst_low == 0));
        if (rst_low > 0) rst_low--;
        chk("err_count", 32'(err_count), 32'(exp_err));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    // Receiver stand-in: start bit low, body cycles, then 16-cycle done level
    task automatic frame(input logic [7:0] b, input bit err, input int body, input bit pop_at_done);
        rx = 1'b0;
        for (int i = 0; i < body; i++) begin
            step();
            rx = 1'($urandom);
            if (err && (i == body / 2)) rx_err = 1'b1;
        end
        rx      = 1'b1;
        rx_data = b;
        rx_done = 1'b1;
        if (pop_at_done) m_ready = 1'b1;
        if (err) pend_err = 1'b1;
        else begin
            pend_push = 1'b1;
            pend_byte = b;
        end
        step();
        if (pop_at_done) m_ready = 1'b0;
        if (err) begin
            chk("rec_start0", 32'(rx_start), 32'(0));
            step();
            chk("rec_start1", 32'(rx_start), 32'(0));
            step();
            chk("rec_start2", 32'(rx_start), 32'(enable));
            repeat (13) step();
        end else begin
            repeat (15) step();
        end
        rx_done = 1'b0;
        rx_err  = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        cfg_data_len = 4'd8; cfg_parity_en = 1'b0; cfg_parity_type = 1'b0; cfg_stop2 = 1'b0;
        rx = 1'b1; rx_data = 8'd0; rx_done = 1'b0; rx_err = 1'b0;
        @(negedge rx_clk);
        step();
        step();
        chk("rst_rx_start", 32'(rx_start), 32'(0));
        chk("rst_data_len", 32'(data_len), 32'(8));
        chk("rst_parity_en", 32'(parity_en), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        rst = 1'b0;

        // Config loading while disabled
        cfg_data_len = 4'd3; step();
        chk("cfg_len3", 32'(data_len), 32'(8));
        cfg_data_len = 4'd6; cfg_parity_en = 1'b1; cfg_parity_type = 1'b1; cfg_stop2 = 1'b1; step();
        chk("cfg_len6", 32'(data_len), 32'(6));
        chk("cfg_par", 32'({parity_en, parity_type, stop2}), 32'(3'b111));
        cfg_data_len = 4'd9; step();
        chk("cfg_len9", 32'(data_len), 32'(8));
        cfg_data_len = 4'd8; cfg_parity_en = 1'b0; cfg_parity_type = 1'b0; cfg_stop2 = 1'b0; step();
        chk("cfg_8n1", 32'({data_len, parity_en, parity_type, stop2}), 32'({4'd8, 3'b000}));
        chk("dis_rx_start", 32'(rx_start), 32'(0));

        // Enable latency and a good 8N1 frame
        enable = 1'b1; step();
        chk("en_rx_start", 32'(rx_start), 32'(1));
        m_ready = 1'b1;
        frame(8'hA5, 1'b0, 150, 1'b0);
        chk("good_err", 32'(err_count), 32'(0));

        // Push and pop on the same edge with a full FIFO
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) frame(8'($urandom), 1'b0, int'($urandom_range(60, 10)), 1'b0);
        frame(8'($urandom), 1'b0, int'($urandom_range(60, 10)), 1'b1);
        chk("full_pushpop_ovf", 32'(overflow), 32'(0));
        m_ready = 1'b1;
        repeat (8) step();
        chk("drain1_valid", 32'(m_valid), 32'(0));

        // Done rise on the same edge as the timeout resolves as done
        frame(8'($urandom), 1'b0, int'(TIMEOUT), 1'b0);
        chk("race_err", 32'(err_count), 32'(0));

        // Config frozen while armed, reloads once disabled
        cfg_data_len = 4'd5;
        repeat (3) step();
        chk("armed_len", 32'(data_len), 32'(8));
        enable = 1'b0; step();
        chk("dis_start", 32'(rx_start), 32'(0));
        chk("dis_len0", 32'(data_len), 32'(8));
        step();
        chk("dis_len1", 32'(data_len), 32'(5));

        // 7E1 frame with a parity error
        cfg_data_len = 4'd7; cfg_parity_en = 1'b1; cfg_parity_type = 1'b0; step();
        chk("cfg_7e1", 32'({data_len, parity_en, parity_type}), 32'({4'd7, 2'b10}));
        enable = 1'b1; step();
        frame(8'($urandom), 1'b1, int'($urandom_range(150, 20)), 1'b0);
        chk("par_err", 32'(err_count), 32'(1));

        // Stalled frame: rx low with no done
        rx = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i == int'(TIMEOUT)) pend_err = 1'b1;
            step();
            chk("stall_start", 32'(rx_start), 32'(!((i == int'(TIMEOUT)) || (i == int'(TIMEOUT) + 1))));
        end
        chk("stall_err", 32'(err_count), 32'(2));
        rx = 1'b1; rx_data = 8'($urandom); rx_done = 1'b1;
        pend_push = 1'b1; pend_byte = rx_data;
        repeat (16) step();
        rx_done = 1'b0;
        repeat (3) step();

        // Overflow: five frames into a four-entry FIFO
        m_ready = 1'b0;
        for (int v = 1; v <= 5; v++) frame(8'(v), 1'b0, int'($urandom_range(60, 10)), 1'b0);
        chk("ovf_set", 32'(overflow), 32'(1));
        m_ready = 1'b1;
        repeat (6) step();
        chk("ovf_drain_valid", 32'(m_valid), 32'(0));

        // Reset in the middle of a frame with data buffered
        m_ready = 1'b0;
        frame(8'h3C, 1'b0, 20, 1'b0);
        rx = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        q.delete(); exp_err = 0; exp_ovf = 1'b0; rst_low = 0;
        #1;
        step();
        chk("mid_rx_start", 32'(rx_start), 32'(0));
        chk("mid_cfg", 32'({data_len, parity_en, parity_type, stop2}), 32'({4'd8, 3'b000}));
        chk("mid_m", 32'({m_valid, m_data}), 32'(0));
        chk("mid_cnt", 32'({overflow, err_count}), 32'(0));
        rx = 1'b1; rst = 1'b0;
        step();
        step();

        // Error counter saturation
        for (int n = 0; n < 260; n++) frame(8'($urandom), 1'b1, int'($urandom_range(12, 2)), 1'b0);
        chk("sat_err", 32'(err_count), 32'(255));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
